// File: rtl/mips_e_pkg.sv
// mips_e_pkg: shared definitions for the MIPS execute stage.
//   - ALU_* function codes (3 bits) and MD_* multiply/divide op codes (4 bits)
//   - hilo_t: HI/LO register pair
//   - md_norm():    folds unused MD codes onto MD_NONE
//   - md_compute(): 64-bit product or quotient/remainder for one MD op
package mips_e_pkg;

    localparam int ALU_OP_W = 3;
    localparam int MD_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd7;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Codes above MD_MFLO are reserved and behave as "no operation".
    function automatic logic [MD_OP_W-1:0] md_norm(input logic [MD_OP_W-1:0] op);
        logic [MD_OP_W-1:0] res;
        if (op > MD_MFLO) begin
            res = MD_NONE;
        end else begin
            res = op;
        end
        return res;
    endfunction

    // Signed division is done on magnitudes so that 0x80000000 / -1 needs no
    // special case: |a| = 0x80000000 fits unsigned, and negating it wraps back.
    function automatic hilo_t md_compute(input logic [MD_OP_W-1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        hilo_t       res;
        logic [63:0] prod;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        res   = '0;
        prod  = 64'd0;
        a_mag = a[31] ? (32'd0 - a) : a;
        b_mag = b[31] ? (32'd0 - b) : b;
        q_mag = 32'd0;
        r_mag = 32'd0;
        case (op)
            MD_MULT: begin
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MD_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MD_DIV: begin
                if (b != 32'd0) begin
                    q_mag  = a_mag / b_mag;
                    r_mag  = a_mag % b_mag;
                    res.lo = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
                    res.hi = a[31] ? (32'd0 - r_mag) : r_mag;
                end else begin
                    res = '0;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    res.lo = a / b;
                    res.hi = a % b;
                end else begin
                    res = '0;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_md_stage_md_unit.sv
// md_unit: multi-cycle multiply/divide engine with the HI/LO registers.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   valid           instruction in E is real
//   md_op           normalized MD op code of the instruction in E
//   rs, rt          forwarded operands
//   busy            operation in progress (registered)
//   stall           HI/LO access conflicts with the running operation
//   hi, lo          current HI/LO contents (registered)
module md_unit
    import mips_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs,
    input  logic [31:0]        rt,
    output logic               busy,
    output logic               stall,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [MD_OP_W-1:0] op_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    hilo_t              hilo_r;

    logic  is_md_s;
    logic  start_s;
    logic  done_s;
    logic  div_zero_s;
    logic  mt_ok_s;
    hilo_t result_s;

    assign is_md_s    = (md_op >= MD_MULT) && (md_op <= MD_DIVU);
    assign start_s    = valid && is_md_s && !busy_r;
    assign stall      = valid && (md_op != MD_NONE) && busy_r;
    assign done_s     = (cnt_r == CNT_ONE);
    // A zero divisor burns the full latency but must leave HI/LO untouched.
    assign div_zero_s = ((op_r == MD_DIV) || (op_r == MD_DIVU)) && (b_r == 32'd0);
    assign mt_ok_s    = valid && !stall;
    assign result_s   = md_compute(op_r, a_r, b_r);

    assign busy = busy_r;
    assign hi   = hilo_r.hi;
    assign lo   = hilo_r.lo;

    // Operand latch, countdown and busy flag for the running operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
            op_r   <= MD_NONE;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
        end else if (start_s) begin
            cnt_r  <= (md_op <= MD_MULTU) ? MULT_LOAD : DIV_LOAD;
            busy_r <= 1'b1;
            op_r   <= md_op;
            a_r    <= rs;
            b_r    <= rt;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r  <= cnt_r - CNT_ONE;
            busy_r <= !done_s;
        end else begin
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    // HI/LO update: result on the final count, or mthi/mtlo when not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hilo_r <= '0;
        end else if (done_s && !div_zero_s) begin
            hilo_r <= result_s;
        end else if (mt_ok_s && (md_op == MD_MTHI)) begin
            hilo_r.hi <= rs;
        end else if (mt_ok_s && (md_op == MD_MTLO)) begin
            hilo_r.lo <= rs;
        end else begin
            hilo_r <= hilo_r;
        end
    end

endmodule

// File: rtl/execute_md_stage.sv
// execute_md_stage: MIPS execute stage with ALU, multiply/divide unit and
// the E/M pipeline register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valid_E_i                  instruction in E is real (0 = bubble)
//   rs_E_i, rt_E_i, extimm_E_i operands and extended immediate
//   bsel_E_i                   ALU B select (1 = immediate)
//   alu_op_E_i, md_op_E_i      ALU and MD op codes
//   A3_E_i, regWrite_E_i       destination register and write enable
//   md_stall_o                 freeze upstream, bubble into E/M
//   md_busy_o                  multi-cycle operation in progress
//   result_M_o, A3_M_o, regWrite_M_o   E/M register outputs
module execute_md_stage
    import mips_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_E_i,
    input  logic [31:0]         rs_E_i,
    input  logic [31:0]         rt_E_i,
    input  logic [31:0]         extimm_E_i,
    input  logic                bsel_E_i,
    input  logic [ALU_OP_W-1:0] alu_op_E_i,
    input  logic [MD_OP_W-1:0]  md_op_E_i,
    input  logic [4:0]          A3_E_i,
    input  logic                regWrite_E_i,
    output logic                md_stall_o,
    output logic                md_busy_o,
    output logic [31:0]         result_M_o,
    output logic [4:0]          A3_M_o,
    output logic                regWrite_M_o
);

    logic [MD_OP_W-1:0] md_op_s;
    logic [31:0]        alu_b_s;
    logic [31:0]        alu_res_s;
    logic [31:0]        result_s;
    logic [31:0]        hi_s;
    logic [31:0]        lo_s;

    assign md_op_s = md_norm(md_op_E_i);
    assign alu_b_s = bsel_E_i ? extimm_E_i : rt_E_i;

    md_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_unit (
        .clk   (clk),
        .reset (reset),
        .valid (valid_E_i),
        .md_op (md_op_s),
        .rs    (rs_E_i),
        .rt    (rt_E_i),
        .busy  (md_busy_o),
        .stall (md_stall_o),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // ALU: 32-bit wrap-around arithmetic and logic.
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_op_E_i)
            ALU_ADD:  alu_res_s = rs_E_i + alu_b_s;
            ALU_SUB:  alu_res_s = rs_E_i - alu_b_s;
            ALU_OR:   alu_res_s = rs_E_i | alu_b_s;
            ALU_AND:  alu_res_s = rs_E_i & alu_b_s;
            ALU_SLT:  alu_res_s = {31'd0, ($signed(rs_E_i) < $signed(alu_b_s))};
            ALU_SLTU: alu_res_s = {31'd0, (rs_E_i < alu_b_s)};
            ALU_LUI:  alu_res_s = {alu_b_s[15:0], 16'd0};
            ALU_PASS: alu_res_s = alu_b_s;
            default:  alu_res_s = 32'd0;
        endcase
    end

    // E result: HI/LO reads take priority over the ALU output.
    always_comb begin
        result_s = alu_res_s;
        if (md_op_s == MD_MFHI) begin
            result_s = hi_s;
        end else if (md_op_s == MD_MFLO) begin
            result_s = lo_s;
        end else begin
            result_s = alu_res_s;
        end
    end

    // E/M register: bubble on stall or empty E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_M_o   <= 32'd0;
            A3_M_o       <= 5'd0;
            regWrite_M_o <= 1'b0;
        end else if (md_stall_o || !valid_E_i) begin
            result_M_o   <= 32'd0;
            A3_M_o       <= 5'd0;
            regWrite_M_o <= 1'b0;
        end else begin
            result_M_o   <= result_s;
            A3_M_o       <= A3_E_i;
            regWrite_M_o <= regWrite_E_i;
        end
    end

endmodule

// File: tb/tb_execute_md_stage.sv
// Self-checking bench for execute_md_stage: directed cases plus randomized
// instruction streams compared against a behavioural model.
module tb_execute_md_stage;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] rs, rt, imm;
    logic        bsel;
    logic [2:0]  alu;
    logic [3:0]  md;
    logic [4:0]  a3;
    logic        rw;
    logic        md_stall_o, md_busy_o;
    logic [31:0] result_M_o;
    logic [4:0]  A3_M_o;
    logic        regWrite_M_o;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] hi_m, lo_m, phi, plo;
    bit          pwr;
    int          cnt_m;
    logic [31:0] res_exp;
    logic [4:0]  a3_exp;
    bit          rw_exp;
    bit          last_stall;

    execute_md_stage #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_E_i    (valid),
        .rs_E_i       (rs),
        .rt_E_i       (rt),
        .extimm_E_i   (imm),
        .bsel_E_i     (bsel),
        .alu_op_E_i   (alu),
        .md_op_E_i    (md),
        .A3_E_i       (a3),
        .regWrite_E_i (rw),
        .md_stall_o   (md_stall_o),
        .md_busy_o    (md_busy_o),
        .result_M_o   (result_M_o),
        .A3_M_o       (A3_M_o),
        .regWrite_M_o (regWrite_M_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a & b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return b << 16;
            default: return b;
        endcase
    endfunction

    task automatic model_reset();
        hi_m = 32'd0; lo_m = 32'd0; phi = 32'd0; plo = 32'd0; pwr = 1'b0;
        cnt_m = 0; res_exp = 32'd0; a3_exp = 5'd0; rw_exp = 1'b0; last_stall = 1'b0;
    endtask

    // One clock: check combinational/busy outputs, advance model, check E/M.
    task automatic step();
        int          op;
        int          old;
        bit          busy_e, stall_e;
        logic [31:0] b, res_e;
        longint      sp, sq, sr;
        longint unsigned up;
        @(negedge clk);
        op      = (md > 4'd8) ? 0 : int'(md);
        busy_e  = (cnt_m > 0);
        stall_e = valid && (op != 0) && busy_e;
        b       = bsel ? imm : rt;
        res_e   = (op == 7) ? hi_m : (op == 8) ? lo_m : alu_ref(alu, rs, b);
        check_eq("busy", {31'd0, md_busy_o}, {31'd0, busy_e});
        check_eq("stall", {31'd0, md_stall_o}, {31'd0, stall_e});
        @(posedge clk);
        if (stall_e || !valid) begin
            res_exp = 32'd0; a3_exp = 5'd0; rw_exp = 1'b0;
        end else begin
            res_exp = res_e; a3_exp = a3; rw_exp = rw;
        end
        old = cnt_m;
        if (old == 1 && pwr) begin
            hi_m = phi; lo_m = plo;
        end
        if (old > 0) cnt_m = old - 1;
        if (valid && op >= 1 && op <= 4 && old == 0) begin
            cnt_m = (op <= 2) ? MC : DC;
            pwr   = 1'b1;
            case (op)
                1: begin
                    sp = longint'($signed(rs)) * longint'($signed(rt));
                    phi = sp[63:32]; plo = sp[31:0];
                end
                2: begin
                    up = {32'd0, rs} * {32'd0, rt};
                    phi = up[63:32]; plo = up[31:0];
                end
                3: begin
                    if (rt == 32'd0) pwr = 1'b0;
                    else begin
                        sq = longint'($signed(rs)) / longint'($signed(rt));
                        sr = longint'($signed(rs)) % longint'($signed(rt));
                        plo = sq[31:0]; phi = sr[31:0];
                    end
                end
                default: begin
                    if (rt == 32'd0) pwr = 1'b0;
                    else begin
                        plo = rs / rt; phi = rs % rt;
                    end
                end
            endcase
        end
        if (valid && !stall_e && op == 5) hi_m = rs;
        if (valid && !stall_e && op == 6) lo_m = rs;
        last_stall = stall_e;
        #1;
        check_eq("result_M", result_M_o, res_exp);
        check_eq("A3_M", {27'd0, A3_M_o}, {27'd0, a3_exp});
        check_eq("regWrite_M", {31'd0, regWrite_M_o}, {31'd0, rw_exp});
    endtask

    // Present one instruction and hold it in E until it is accepted.
    task automatic issue(input bit v, input logic [31:0] a, input logic [31:0] bb,
                         input logic [31:0] im, input bit bs, input logic [2:0] al,
                         input logic [3:0] m, input logic [4:0] d, input bit w,
                         output int stalls);
        valid = v; rs = a; rt = bb; imm = im; bsel = bs; alu = al; md = m; a3 = d; rw = w;
        stalls = 0;
        step();
        while (last_stall && stalls < 64) begin
            stalls++;
            step();
        end
        check_eq("stall_bound", {31'd0, last_stall}, 32'd0);
    endtask

    initial begin
        int s;
        logic [31:0] ra, rb;
        reset = 1'b1; valid = 1'b0; rs = 32'd0; rt = 32'd0; imm = 32'd0;
        bsel = 1'b0; alu = 3'd0; md = 4'd0; a3 = 5'd0; rw = 1'b0;
        model_reset();
        #12;
        check_eq("rst_result", result_M_o, 32'd0);
        check_eq("rst_a3", {27'd0, A3_M_o}, 32'd0);
        check_eq("rst_rw", {31'd0, regWrite_M_o}, 32'd0);
        check_eq("rst_busy", {31'd0, md_busy_o}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // ALU directed
        issue(1, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 3'd4, 4'd0, 5'd3, 1, s);
        check_eq("slt", result_M_o, 32'd1);
        issue(1, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 3'd5, 4'd0, 5'd3, 1, s);
        check_eq("sltu", result_M_o, 32'd0);
        issue(1, 32'd0, 32'd0, 32'h1234, 1, 3'd6, 4'd0, 5'd4, 1, s);
        check_eq("lui", result_M_o, 32'h12340000);

        // mult / multu
        issue(1, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 3'd0, 4'd1, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd2, 1, s);
        check_eq("mult_stalls", s, 32'd5);
        check_eq("mult_hi", result_M_o, 32'hFFFFFFFF);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd2, 1, s);
        check_eq("mult_lo", result_M_o, 32'hFFFFFFF1);
        issue(1, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 3'd0, 4'd2, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd2, 1, s);
        check_eq("multu_hi", result_M_o, 32'h00000004);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd2, 1, s);
        check_eq("multu_lo", result_M_o, 32'hFFFFFFF1);

        // div 7 / -2
        issue(1, 32'd7, 32'hFFFFFFFE, 32'd0, 0, 3'd0, 4'd3, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd6, 1, s);
        check_eq("div_stalls", s, 32'd10);
        check_eq("div_lo", result_M_o, 32'hFFFFFFFD);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd6, 1, s);
        check_eq("div_hi", result_M_o, 32'd1);

        // divu by zero keeps HI/LO
        issue(1, 32'd5, 32'd0, 32'd0, 0, 3'd0, 4'd4, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd6, 1, s);
        check_eq("dz_stalls", s, 32'd10);
        check_eq("dz_hi", result_M_o, 32'd1);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd6, 1, s);
        check_eq("dz_lo", result_M_o, 32'hFFFFFFFD);

        // signed overflow divide
        issue(1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 3'd0, 4'd3, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd7, 1, s);
        check_eq("ovf_lo", result_M_o, 32'h80000000);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd7, 1, s);
        check_eq("ovf_hi", result_M_o, 32'd0);

        // reset in the middle of a mult
        issue(1, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 3'd0, 4'd1, 5'd0, 0, s);
        issue(0, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd0, 5'd0, 0, s);
        issue(0, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd0, 5'd0, 0, s);
        reset = 1'b1;
        #2;
        check_eq("rst_mid_busy", {31'd0, md_busy_o}, 32'd0);
        check_eq("rst_mid_result", result_M_o, 32'd0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd8, 5'd1, 1, s);
        check_eq("rst_lo", result_M_o, 32'd0);
        repeat (10) issue(0, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd0, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd1, 1, s);
        check_eq("rst_hi", result_M_o, 32'd0);
        issue(1, 32'hAA, 32'd0, 32'd0, 0, 3'd0, 4'd5, 5'd0, 0, s);
        issue(1, 32'd0, 32'd0, 32'd0, 0, 3'd0, 4'd7, 5'd1, 1, s);
        check_eq("mthi_mfhi", result_M_o, 32'hAA);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            int r;
            ra = $urandom();
            rb = $urandom();
            r  = $urandom_range(0, 7);
            if (r == 0) rb = 32'd0;
            else if (r == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (r == 2) rb = $urandom_range(1, 9);
            issue(($urandom_range(0, 9) != 0), ra, rb, $urandom(), $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1), s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
